// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - word-serial multiword adder around a single N-bit full adder
module full_adder #(
    parameter int N = 3
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = (N+1)'(a) + (N+1)'(b) + (N+1)'(ci);
endmodule

module multiword_add_seq #(
    parameter int N     = 3,
    parameter int WORDS = 4,
    localparam int CW   = $clog2(WORDS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic          in_last,
    input  logic          ci_init,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sum,
    output logic          out_last,
    output logic          out_cout,
    output logic [CW-1:0] out_idx,
    output logic          seq_err
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           valid_q, valid_d;
    logic [N-1:0]   sum_q, sum_d;
    logic           last_q, last_d;
    logic           cout_q, cout_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic           err_q, err_d;

    logic           accept, emit, overlen, close_pkt;
    logic           fa_ci, fa_cout;
    logic [N-1:0]   fa_sum;

    full_adder #(.N(N)) u_fa (
        .a    (in_a),
        .b    (in_b),
        .ci   (fa_ci),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept    = in_valid && in_ready;
    assign emit      = valid_q && out_ready;
    // The WORDS-th word closes the packet even without in_last, flagging the error.
    assign overlen   = (cnt_q == CW'(WORDS - 1)) && !in_last;
    assign close_pkt = in_last || overlen;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = close_pkt ? IDLE : BUSY;
        end
    end

    always_comb begin
        in_ready = !valid_q || out_ready;
        fa_ci    = (state_q == IDLE) ? ci_init : carry_q;
    end

    always_comb begin
        carry_d = carry_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        sum_d   = sum_q;
        last_d  = last_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            sum_d   = fa_sum;
            cout_d  = fa_cout;
            last_d  = close_pkt;
            idx_d   = cnt_q;
            carry_d = close_pkt ? 1'b0 : fa_cout;
            cnt_d   = close_pkt ? '0 : cnt_q + CW'(1);
            err_d   = err_q || overlen;
        end else if (emit) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_last  = last_q;
    assign out_cout  = cout_q;
    assign out_idx   = idx_q;
    assign seq_err   = err_q;
endmodule
